// File: rtl/aes256_top.sv
// AES-256 known-answer self-test: expands a fixed key, encrypts a fixed block,
// decrypts the produced ciphertext and flags whether both match the known answers.

package aes256_pkg;
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 by square-and-multiply; also maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gf_mul(r, r);
            if (i != 0) r = gf_mul(r, a);
        end
        return r;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    // byte i of the state lives at bits [127-8i -: 8], column-major
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? ((c - r + 4) % 4) : ((c + r) % 4);
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*src+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[127-8*(4*c+r) -: 8];
            for (int r = 0; r < 4; r++) begin
                if (inv)
                    o[127-8*(4*c+r) -: 8] = gf_mul(a[r], 8'h0e) ^ gf_mul(a[(r+1)%4], 8'h0b)
                                          ^ gf_mul(a[(r+2)%4], 8'h0d) ^ gf_mul(a[(r+3)%4], 8'h09);
                else
                    o[127-8*(4*c+r) -: 8] = xtime(a[r]) ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4]
                                          ^ a[(r+2)%4] ^ a[(r+3)%4];
            end
        end
        return o;
    endfunction
endpackage

module aes256_sbox #(
    parameter bit INV = 1'b0
) (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    import aes256_pkg::*;

    always_comb begin
        if (INV) y_o = gf_inv(inv_affine(a_i));
        else     y_o = affine(gf_inv(a_i));
    end
endmodule

module aes256_top #(
    parameter logic [255:0] KEY         = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
    parameter logic [127:0] PLAINTEXT   = 128'h00112233445566778899aabbccddeeff,
    parameter logic [127:0] EXPECTED_CT = 128'h8ea2b7ca516745bfeafc49904b496089
) (
    input  logic         clk_i,
    input  logic         reset_i,
    output logic         done_o,
    output logic         e256,
    output logic         d256,
    output logic [127:0] encrypted256,
    output logic [127:0] decrypted256
);
    import aes256_pkg::*;

    typedef enum logic [1:0] {S_KEY, S_ENC, S_DEC, S_DONE} state_e;

    state_e       fsm_q, fsm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] st_q, st_d;
    logic [127:0] enc_q, enc_d;
    logic [127:0] dec_q, dec_d;
    logic         done_q, done_d, e_q, e_d, d_q, d_d;

    logic [127:0] rk_q [0:15];
    logic [127:0] rk_w [0:14];
    logic [3:0]   cnt_p1, cnt_p2, dec_idx;
    logic         last;

    assign cnt_p1  = cnt_q + 4'd1;
    assign cnt_p2  = cnt_q + 4'd2;
    assign dec_idx = 4'd13 - cnt_q;
    assign last    = (cnt_q == 4'd13);

    always_comb begin
        rk_w[0] = KEY[255:128];
        rk_w[1] = KEY[127:0];
        for (int k = 2; k < 15; k++) rk_w[k] = rk_q[k];
    end

    // Key schedule: round key k (= cnt+2) from keys k-2 and k-1
    logic [127:0] kprev2, kprev1, rk_new;
    logic [31:0]  kw, sub_in, sub_out, temp, w0, w1, w2, w3;
    logic [7:0]   rcon;
    logic         kodd;

    assign kprev2  = rk_w[cnt_q];
    assign kprev1  = rk_w[cnt_p1];
    assign kodd    = cnt_p2[0];
    assign kw      = kprev1[31:0];
    assign sub_in  = kodd ? kw : {kw[23:0], kw[31:24]};
    assign rcon    = 8'h01 << (cnt_p2[3:1] - 3'd1);
    assign temp    = kodd ? sub_out : (sub_out ^ {rcon, 24'h0});
    assign w0      = kprev2[127:96] ^ temp;
    assign w1      = kprev2[95:64]  ^ w0;
    assign w2      = kprev2[63:32]  ^ w1;
    assign w3      = kprev2[31:0]   ^ w2;
    assign rk_new  = {w0, w1, w2, w3};

    // Round datapath: 16 forward and 16 inverse S-box lanes, 4 lanes for SubWord
    logic [127:0] sb_fwd, isr, isb, rk_sel, sr, enc_out, dec_ark, dec_out;

    assign isr = shift_rows(st_q, 1'b1);

    for (genvar i = 0; i < 16; i++) begin : g_lane
        aes256_sbox #(.INV(1'b0)) u_fwd (.a_i(st_q[127-8*i -: 8]), .y_o(sb_fwd[127-8*i -: 8]));
        aes256_sbox #(.INV(1'b1)) u_inv (.a_i(isr[127-8*i -: 8]),  .y_o(isb[127-8*i -: 8]));
    end

    for (genvar i = 0; i < 4; i++) begin : g_ks
        aes256_sbox #(.INV(1'b0)) u_ks (.a_i(sub_in[31-8*i -: 8]), .y_o(sub_out[31-8*i -: 8]));
    end

    assign rk_sel  = (fsm_q == S_ENC) ? rk_w[cnt_p1] : rk_w[dec_idx];
    assign sr      = shift_rows(sb_fwd, 1'b0);
    assign enc_out = (last ? sr : mix_columns(sr, 1'b0)) ^ rk_sel;
    assign dec_ark = isb ^ rk_sel;
    assign dec_out = last ? dec_ark : mix_columns(dec_ark, 1'b1);

    always_comb begin
        fsm_d  = fsm_q;
        cnt_d  = cnt_q;
        st_d   = st_q;
        enc_d  = enc_q;
        dec_d  = dec_q;
        done_d = done_q;
        e_d    = e_q;
        d_d    = d_q;
        case (fsm_q)
            S_KEY: begin
                cnt_d = cnt_p1;
                if (cnt_q == 4'd12) begin
                    fsm_d = S_ENC;
                    cnt_d = '0;
                    st_d  = PLAINTEXT ^ rk_w[0];
                end
            end
            S_ENC: begin
                cnt_d = cnt_p1;
                st_d  = enc_out;
                if (last) begin
                    fsm_d = S_DEC;
                    cnt_d = '0;
                    enc_d = enc_out;
                    st_d  = enc_out ^ rk_w[14];
                end
            end
            S_DEC: begin
                cnt_d = cnt_p1;
                st_d  = dec_out;
                if (last) begin
                    fsm_d  = S_DONE;
                    cnt_d  = '0;
                    dec_d  = dec_out;
                    done_d = 1'b1;
                    e_d    = (enc_q == EXPECTED_CT);
                    d_d    = (dec_out == PLAINTEXT);
                end
            end
            S_DONE:  ;
            default: fsm_d = S_KEY;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_q  <= S_KEY;
            cnt_q  <= '0;
            st_q   <= '0;
            enc_q  <= '0;
            dec_q  <= '0;
            done_q <= 1'b0;
            e_q    <= 1'b0;
            d_q    <= 1'b0;
        end else begin
            fsm_q  <= fsm_d;
            cnt_q  <= cnt_d;
            st_q   <= st_d;
            enc_q  <= enc_d;
            dec_q  <= dec_d;
            done_q <= done_d;
            e_q    <= e_d;
            d_q    <= d_d;
        end
    end

    // Round-key file needs no reset: every entry is rewritten before use
    always_ff @(posedge clk_i) begin
        if (fsm_q == S_KEY) rk_q[cnt_p2] <= rk_new;
    end

    assign done_o       = done_q;
    assign e256         = e_q;
    assign d256         = d_q;
    assign encrypted256 = enc_q;
    assign decrypted256 = dec_q;
endmodule

// File: tb/tb_aes256_top.sv
// Directed known-answer bench for aes256_top: default vectors, latency, reset abort,
// an alternate key/plaintext and a deliberately wrong expected ciphertext.

module tb_aes256_top;
    localparam logic [127:0] CT_DEF = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_DEF = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY_N  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] PT_N   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] CT_N   = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         done, e, d, n_done, n_e, n_d, b_done, b_e, b_d;
    logic [127:0] enc, dec, n_enc, n_dec, b_enc, b_dec;

    aes256_top u_dut (
        .clk_i(clk), .reset_i(rst), .done_o(done), .e256(e), .d256(d),
        .encrypted256(enc), .decrypted256(dec)
    );

    aes256_top #(.KEY(KEY_N), .PLAINTEXT(PT_N), .EXPECTED_CT(CT_N)) u_nist (
        .clk_i(clk), .reset_i(rst), .done_o(n_done), .e256(n_e), .d256(n_d),
        .encrypted256(n_enc), .decrypted256(n_dec)
    );

    aes256_top #(.EXPECTED_CT(128'h0)) u_bad (
        .clk_i(clk), .reset_i(rst), .done_o(b_done), .e256(b_e), .d256(b_d),
        .encrypted256(b_enc), .decrypted256(b_dec)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int           edge_n;
        logic         done;
        logic         e;
        logic         d;
        logic [127:0] enc;
        logic [127:0] dec;
    } vec_t;

    localparam int NV = 6;
    vec_t vec [NV];

    task automatic chk_outs(input string tag, input logic xd, input logic xe, input logic xdd,
                            input logic [127:0] xenc, input logic [127:0] xdec);
        chk({tag, "_done"}, {127'h0, done}, {127'h0, xd});
        chk({tag, "_e256"}, {127'h0, e},    {127'h0, xe});
        chk({tag, "_d256"}, {127'h0, d},    {127'h0, xdd});
        chk({tag, "_enc"},  enc,  xenc);
        chk({tag, "_dec"},  dec,  xdec);
    endtask

    initial begin
        int vi;
        vec[0] = '{13, 1'b0, 1'b0, 1'b0, 128'h0,  128'h0};
        vec[1] = '{26, 1'b0, 1'b0, 1'b0, 128'h0,  128'h0};
        vec[2] = '{28, 1'b0, 1'b0, 1'b0, CT_DEF,  128'h0};
        vec[3] = '{40, 1'b0, 1'b0, 1'b0, CT_DEF,  128'h0};
        vec[4] = '{41, 1'b1, 1'b1, 1'b1, CT_DEF,  PT_DEF};
        vec[5] = '{50, 1'b1, 1'b1, 1'b1, CT_DEF,  PT_DEF};

        // reset held for 5 cycles
        repeat (5) @(posedge clk);
        #1 chk_outs("reset", 1'b0, 1'b0, 1'b0, 128'h0, 128'h0);
        @(negedge clk) rst = 1'b0;

        vi = 0;
        for (int n = 1; n <= 50; n++) begin
            @(posedge clk);
            #1;
            if (n <= 40)
                chk($sformatf("early_zero_e%0d", n), {124'h0, done, e, d, |dec}, 128'h0);
            if (vi < NV && vec[vi].edge_n == n) begin
                chk_outs($sformatf("vec_e%0d", n), vec[vi].done, vec[vi].e, vec[vi].d,
                         vec[vi].enc, vec[vi].dec);
                vi++;
            end
        end

        chk("nist_done", {127'h0, n_done}, 128'h1);
        chk("nist_e256", {127'h0, n_e},    128'h1);
        chk("nist_d256", {127'h0, n_d},    128'h1);
        chk("nist_enc",  n_enc, CT_N);
        chk("nist_dec",  n_dec, PT_N);
        chk("bad_done",  {127'h0, b_done}, 128'h1);
        chk("bad_e256",  {127'h0, b_e},    128'h0);
        chk("bad_d256",  {127'h0, b_d},    128'h1);
        chk("bad_enc",   b_enc, CT_DEF);
        chk("bad_dec",   b_dec, PT_DEF);

        // reset from DONE clears outputs without waiting for a clock edge
        @(negedge clk) rst = 1'b1;
        #1 chk_outs("async_from_done", 1'b0, 1'b0, 1'b0, 128'h0, 128'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        // abort mid-decryption, after the ciphertext is already registered
        repeat (30) @(posedge clk);
        #1 chk("pre_abort_enc", enc, CT_DEF);
        @(negedge clk) rst = 1'b1;
        #1 chk_outs("abort_mid", 1'b0, 1'b0, 1'b0, 128'h0, 128'h0);
        repeat (5) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        repeat (40) @(posedge clk);
        #1 chk_outs("restart_e40", 1'b0, 1'b0, 1'b0, CT_DEF, 128'h0);
        @(posedge clk);
        #1 chk_outs("restart_e41", 1'b1, 1'b1, 1'b1, CT_DEF, PT_DEF);
        repeat (20) @(posedge clk);
        #1 chk_outs("hold_done", 1'b1, 1'b1, 1'b1, CT_DEF, PT_DEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
